// File: rtl/demod_defs.sv
// Shared definitions for the demodulation sequencer and DAC output selector:
// signal-type codes, sequencer state encoding and small helpers.
package demod_defs;

  localparam logic [2:0] SIG_CW  = 3'b000;
  localparam logic [2:0] SIG_AM  = 3'b001;
  localparam logic [2:0] SIG_FM  = 3'b010;
  localparam logic [2:0] SIG_RSV = 3'b011;
  localparam logic [2:0] SIG_NA  = 3'b100;
  localparam logic [2:0] SIG_ASK = 3'b101;
  localparam logic [2:0] SIG_FSK = 3'b110;
  localparam logic [2:0] SIG_PSK = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_MEAS       = 3'd1,
    ST_WAIT_CLASS = 3'd2,
    ST_CAL        = 3'd3,
    ST_OUT        = 3'd4,
    ST_RUN        = 3'd5
  } seq_state_e;

  // The unused classifier code 011 carries no meaning and is reported as NA.
  function automatic logic [2:0] map_class(input logic [2:0] c);
    return (c == SIG_RSV) ? SIG_NA : c;
  endfunction

  // Timer load value for a window of len cycles; a zero length behaves as one.
  function automatic logic [31:0] len_m1(input logic [31:0] len);
    return (len == 32'd0) ? 32'd0 : len - 32'd1;
  endfunction

endpackage

// File: rtl/seq_timer.sv
// Reusable 32-bit countdown timer: load a value, count down to zero without
// wrapping, and flag done while counting with the count at zero.
module seq_timer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic [31:0] load_val_i,
  input  logic        count_i,
  output logic        done_o
);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (count_i && (cnt_q != 32'd0)) begin
      cnt_d = cnt_q - 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 32'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = count_i && (cnt_q == 32'd0);

endmodule

// File: rtl/demod_sequencer.sv
// Sequences measurement, classification, AGC/DC calibration and output of the
// decided modulation type; all outputs are registered.
module demod_sequencer
  import demod_defs::*;
#(
  parameter logic [31:0] MEAS_LEN      = 32'd100000,
  parameter logic [31:0] CAL_LEN       = 32'd50000,
  parameter logic [31:0] CLASS_TIMEOUT = 32'd200000,
  parameter logic [31:0] REFRESH_LEN   = 32'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       restart,
  input  logic       class_valid,
  input  logic [2:0] class_type,
  output logic       meas_trigger,
  output logic       cal_trigger,
  output logic       out_trigger,
  output logic [2:0] signal_type,
  output logic       busy,
  output logic       timeout
);

  seq_state_e  state_q, state_d;
  logic        meas_q, meas_d;
  logic        cal_q, cal_d;
  logic        out_q, out_d;
  logic [2:0]  sig_q, sig_d;
  logic [2:0]  lat_q, lat_d;
  logic        to_q, to_d;
  logic        busy_q, busy_d;

  logic        tmr_load;
  logic [31:0] tmr_val;
  logic        tmr_count;
  logic        tmr_done;
  logic        go_meas;

  seq_timer u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .count_i    (tmr_count),
    .done_o     (tmr_done)
  );

  // Priority: enable low, then restart, then the per-state rules.
  always_comb begin
    state_d   = state_q;
    meas_d    = 1'b0;
    cal_d     = 1'b0;
    out_d     = 1'b0;
    sig_d     = sig_q;
    lat_d     = lat_q;
    to_d      = to_q;
    tmr_load  = 1'b0;
    tmr_val   = 32'd0;
    tmr_count = 1'b0;
    go_meas   = 1'b0;

    if (!enable) begin
      state_d = ST_IDLE;
      sig_d   = SIG_NA;
    end else if (restart && (state_q != ST_IDLE)) begin
      go_meas = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: go_meas = 1'b1;
        ST_MEAS: begin
          tmr_count = 1'b1;
          if (tmr_done) begin
            state_d  = ST_WAIT_CLASS;
            tmr_load = 1'b1;
            tmr_val  = len_m1(CLASS_TIMEOUT);
          end
        end
        ST_WAIT_CLASS: begin
          tmr_count = 1'b1;
          if (class_valid) begin
            lat_d    = map_class(class_type);
            state_d  = ST_CAL;
            cal_d    = 1'b1;
            tmr_load = 1'b1;
            tmr_val  = len_m1(CAL_LEN);
          end else if (tmr_done) begin
            lat_d   = SIG_NA;
            to_d    = 1'b1;
            state_d = ST_OUT;
            out_d   = 1'b1;
            sig_d   = SIG_NA;
          end
        end
        ST_CAL: begin
          tmr_count = 1'b1;
          if (tmr_done) begin
            state_d = ST_OUT;
            out_d   = 1'b1;
            sig_d   = lat_q;
          end
        end
        ST_OUT: begin
          state_d  = ST_RUN;
          tmr_load = 1'b1;
          tmr_val  = len_m1(REFRESH_LEN);
        end
        ST_RUN: begin
          if (REFRESH_LEN != 32'd0) begin
            tmr_count = 1'b1;
            if (tmr_done) begin
              go_meas = 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (go_meas) begin
      state_d  = ST_MEAS;
      meas_d   = 1'b1;
      sig_d    = SIG_NA;
      lat_d    = SIG_NA;
      to_d     = 1'b0;
      tmr_load = 1'b1;
      tmr_val  = len_m1(MEAS_LEN);
    end

    busy_d = !((state_d == ST_IDLE) || (state_d == ST_RUN));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      meas_q  <= 1'b0;
      cal_q   <= 1'b0;
      out_q   <= 1'b0;
      sig_q   <= SIG_NA;
      lat_q   <= SIG_NA;
      to_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      meas_q  <= meas_d;
      cal_q   <= cal_d;
      out_q   <= out_d;
      sig_q   <= sig_d;
      lat_q   <= lat_d;
      to_q    <= to_d;
      busy_q  <= busy_d;
    end
  end

  assign meas_trigger = meas_q;
  assign cal_trigger  = cal_q;
  assign out_trigger  = out_q;
  assign signal_type  = sig_q;
  assign busy         = busy_q;
  assign timeout      = to_q;

endmodule

// File: tb/tb_demod_sequencer.sv
// Self-checking bench for demod_sequencer: table vectors, randomized
// transactions against an arithmetic timeline model, and hand-written corners.
module tb_demod_sequencer;

  localparam int MEAS    = 10;
  localparam int CAL     = 5;
  localparam int TMO     = 20;
  localparam int REFRESH = 8;
  localparam int LAST    = 45;
  localparam logic [2:0] NA = 3'b100;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       restart;
  logic       class_valid;
  logic [2:0] class_type;

  logic       mt0, ct0, ot0, bz0, to0;
  logic [2:0] st0;
  logic       mt1, ct1, ot1, bz1, to1;
  logic [2:0] st1;

  int nChecks = 0;
  int nFails  = 0;

  int measCnt, calCnt, outCnt, firstMeas, calCyc, outCyc;
  int meas1Cnt, secondMeas1, oneHotErr, oneHotErr1;
  logic [2:0] sigAtOut;
  logic       toAtOut;
  logic       measAt [0:63];
  logic       busyAt [0:63];
  logic       toAt   [0:63];
  logic [2:0] sigAt  [0:63];

  typedef struct {
    int         delay;
    logic [2:0] ctype;
    bit         stale;
    logic [2:0] expSig;
    int         expCal;
    int         expOut;
    bit         expTo;
  } vec_t;

  vec_t vecs [8];

  demod_sequencer #(
    .MEAS_LEN(32'd10), .CAL_LEN(32'd5), .CLASS_TIMEOUT(32'd20), .REFRESH_LEN(32'd0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .restart(restart),
    .class_valid(class_valid), .class_type(class_type),
    .meas_trigger(mt0), .cal_trigger(ct0), .out_trigger(ot0),
    .signal_type(st0), .busy(bz0), .timeout(to0)
  );

  demod_sequencer #(
    .MEAS_LEN(32'd10), .CAL_LEN(32'd5), .CLASS_TIMEOUT(32'd20), .REFRESH_LEN(32'd8)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .restart(restart),
    .class_valid(class_valid), .class_type(class_type),
    .meas_trigger(mt1), .cal_trigger(ct1), .out_trigger(ot1),
    .signal_type(st1), .busy(bz1), .timeout(to1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    nChecks++;
    if (actual != expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic logic [2:0] mapRef(input logic [2:0] t);
    return (t == 3'b011) ? NA : t;
  endfunction

  // Runs one sequence from IDLE: cycle 0 is the IDLE cycle with enable high.
  task automatic applyStimulus(input int delay, input logic [2:0] ctype,
                               input bit stale, input int restartAt);
    measCnt = 0; calCnt = 0; outCnt = 0; firstMeas = -1; calCyc = -1; outCyc = -1;
    meas1Cnt = 0; secondMeas1 = -1; oneHotErr = 0; oneHotErr1 = 0;
    sigAtOut = 3'b000; toAtOut = 1'b0;
    for (int i = 0; i < 64; i++) begin
      measAt[i] = 1'b0; busyAt[i] = 1'b0; toAt[i] = 1'b0; sigAt[i] = 3'b000;
    end
    @(negedge clk);
    enable = 1'b1;
    for (int cyc = 1; cyc <= LAST; cyc++) begin
      @(posedge clk);
      #1;
      measAt[cyc] = mt0; busyAt[cyc] = bz0; toAt[cyc] = to0; sigAt[cyc] = st0;
      if (mt0) begin measCnt++; if (firstMeas < 0) firstMeas = cyc; end
      if (ct0) begin calCnt++; if (calCyc < 0) calCyc = cyc; end
      if (ot0) begin
        outCnt++;
        if (outCyc < 0) begin outCyc = cyc; sigAtOut = st0; toAtOut = to0; end
      end
      if ((int'(mt0) + int'(ct0) + int'(ot0)) > 1) oneHotErr++;
      if ((int'(mt1) + int'(ct1) + int'(ot1)) > 1) oneHotErr1++;
      if (mt1) begin meas1Cnt++; if (meas1Cnt == 2) secondMeas1 = cyc; end
      class_valid = 1'b0;
      restart     = 1'b0;
      class_type  = 3'b000;
      if (stale && cyc == 5) begin class_valid = 1'b1; class_type = ~ctype; end
      if (cyc == 1 + MEAS + delay) begin class_valid = 1'b1; class_type = ctype; end
      if (cyc == restartAt) restart = 1'b1;
    end
    class_valid = 1'b0;
    restart     = 1'b0;
    enable      = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("drop_sig", st0, NA);
    checkOutput("drop_trig", int'(mt0) + int'(ct0) + int'(ot0), 0);
    checkOutput("drop_busy", bz0, 0);
    checkOutput("drop_sig_refresh", st1, NA);
    checkOutput("drop_busy_refresh", bz1, 0);
  endtask

  task automatic compareTxn(input int expCal, input int expOut,
                            input logic [2:0] expSig, input bit expTo);
    checkOutput("meas_first", firstMeas, 1);
    checkOutput("meas_count", measCnt, 1);
    checkOutput("cal_cycle", calCyc, expCal);
    checkOutput("cal_count", calCnt, (expCal < 0) ? 0 : 1);
    checkOutput("out_cycle", outCyc, expOut);
    checkOutput("out_count", outCnt, 1);
    checkOutput("out_sig", sigAtOut, expSig);
    checkOutput("out_timeout", toAtOut, expTo);
    checkOutput("run_sig_held", sigAt[LAST], expSig);
    checkOutput("pre_out_sig_na", sigAt[expOut - 1], NA);
    checkOutput("busy_meas", busyAt[5], 1);
    checkOutput("busy_out", busyAt[expOut], 1);
    checkOutput("busy_run", busyAt[expOut + 1], 0);
    checkOutput("one_hot", oneHotErr, 0);
    checkOutput("one_hot_refresh", oneHotErr1, 0);
  endtask

  // Timeline derived from the window lengths with plain arithmetic.
  task automatic modelTxn(input int delay, input logic [2:0] ctype);
    int waitStart, validCyc, expCal, expOut;
    waitStart = 1 + MEAS;
    validCyc  = waitStart + delay;
    if (validCyc < waitStart + TMO) begin
      expCal = validCyc + 1;
      expOut = expCal + CAL;
      compareTxn(expCal, expOut, mapRef(ctype), 1'b0);
    end else begin
      expOut = waitStart + TMO;
      compareTxn(-1, expOut, NA, 1'b1);
    end
  endtask

  task automatic resetDuringCal();
    @(negedge clk);
    enable = 1'b1;
    for (int cyc = 1; cyc <= 17; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == 15) checkOutput("rst_pre_cal", ct0, 1);
      class_valid = (cyc == 14);
      class_type  = 3'b010;
    end
    class_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_async_trig", int'(mt0) + int'(ct0) + int'(ot0), 0);
    checkOutput("rst_async_busy", bz0, 0);
    checkOutput("rst_async_timeout", to0, 0);
    checkOutput("rst_async_sig", st0, NA);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_fresh_meas", mt0, 1);
    checkOutput("rst_fresh_busy", bz0, 1);
    @(posedge clk);
    #1;
    checkOutput("rst_meas_pulse", mt0, 0);
    enable  = 1'b0;
    restart = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("en_over_restart_meas", mt0, 0);
    checkOutput("en_over_restart_busy", bz0, 0);
    checkOutput("en_over_restart_sig", st0, NA);
    @(posedge clk);
    #1;
    checkOutput("idle_restart_ignored", int'(mt0) + int'(bz0), 0);
    restart = 1'b0;
  endtask

  initial begin
    vecs[0] = '{3,  3'b010, 1'b0, 3'b010, 15, 20, 1'b0};
    vecs[1] = '{0,  3'b000, 1'b0, 3'b000, 12, 17, 1'b0};
    vecs[2] = '{19, 3'b111, 1'b0, 3'b111, 31, 36, 1'b0};
    vecs[3] = '{20, 3'b101, 1'b0, 3'b100, -1, 31, 1'b1};
    vecs[4] = '{30, 3'b110, 1'b0, 3'b100, -1, 31, 1'b1};
    vecs[5] = '{5,  3'b011, 1'b1, 3'b100, 17, 22, 1'b0};
    vecs[6] = '{7,  3'b001, 1'b1, 3'b001, 19, 24, 1'b0};
    vecs[7] = '{2,  3'b100, 1'b0, 3'b100, 14, 19, 1'b0};

    rst_n = 1'b0; enable = 1'b0; restart = 1'b0; class_valid = 1'b0; class_type = 3'b000;
    #12;
    checkOutput("reset_trig", int'(mt0) + int'(ct0) + int'(ot0), 0);
    checkOutput("reset_busy", bz0, 0);
    checkOutput("reset_timeout", to0, 0);
    checkOutput("reset_sig", st0, NA);
    #13;
    rst_n = 1'b1;

    applyStimulus(3, 3'b010, 1'b0, -1);
    compareTxn(15, 20, 3'b010, 1'b0);
    checkOutput("refresh_meas", secondMeas1, 20 + 1 + REFRESH);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].delay, vecs[i].ctype, vecs[i].stale, -1);
      compareTxn(vecs[i].expCal, vecs[i].expOut, vecs[i].expSig, vecs[i].expTo);
    end

    applyStimulus(3, 3'b010, 1'b0, 14);
    checkOutput("restart_meas", measAt[15], 1);
    checkOutput("restart_meas_count", measCnt, 2);
    checkOutput("restart_sig", sigAt[15], NA);
    checkOutput("restart_timeout", toAt[15], 0);
    checkOutput("restart_no_cal", calCnt, 0);
    checkOutput("restart_reload_out", outCyc, 15 + MEAS + TMO);

    resetDuringCal();

    for (int n = 0; n < 20; n++) begin
      int d;
      logic [2:0] t;
      bit s;
      d = int'($urandom_range(0, 30));
      t = 3'($urandom_range(0, 7));
      s = bit'($urandom_range(0, 1));
      applyStimulus(d, t, s, -1);
      modelTxn(d, t);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
